arb_requester: RTL and testbench
================================

# arb_requester

Requester-side agent for the shared-resource round-robin arbiter. It buffers bursts from a local producer in a FIFO, raises `req` once a complete burst (or a full FIFO) is ready, and streams beats onto the shared bus while granted. It drops `req` after the last beat and waits for `grant` to fall before competing again. One instance sits on each arbiter input; its `req`/`grant` pair connects to one bit of the arbiter's `req`/`grant` vectors.

## Interface
- `DW`, 32: beat data width.
- `DEPTH`, 8: beat FIFO depth, a power of two and at least 2.
- `CW`, derived `$clog2(DEPTH+1)`: width of the occupancy and burst counters.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer beat valid.
- `in_ready`  out  1  FIFO can accept a beat; equals `!full && !rst`.
- `in_data`  in  DW  producer beat payload.
- `in_last`  in  1  marks the final beat of a burst.
- `req`  out  1  registered arbitration request.
- `grant`  in  1  registered grant bit from the arbiter.
- `bus_valid`  out  1  beat presented on the shared bus.
- `bus_ready`  in  1  bus consumer accepts the beat.
- `bus_data`  out  DW  beat payload (FIFO head).
- `bus_last`  out  1  beat is the final beat of the burst.
- `grant_err`  out  1  sticky flag: grant lost mid-burst.

## Operation
- **FIFO:** `DEPTH` entries of {data, last}.
  - Push when `in_valid && in_ready`.
  - Pop when `bus_valid && bus_ready`.
  - Simultaneous push and pop at full or empty is legal: occupancy is unchanged and ordering is preserved.
- **`bursts` counter:** number of buffered `last` beats.
  - +1 on a push with `in_last`; −1 on a pop with `bus_last`.
  - Both in the same cycle leaves it unchanged.
- **Start condition:** `start = (bursts != 0) || full`.
  - A full FIFO with no `last` starts anyway so that bursts longer than `DEPTH` cannot deadlock.
  - During such a burst, `bus_valid` may drop when the FIFO runs empty and resumes as the producer refills it.
- **FSM states:** IDLE, REQ, XFER, RELEASE.
  - **IDLE** (`req`=0): `start` → REQ.
  - **REQ** (`req`=1): `grant`=1 → XFER; otherwise stay.
  - **XFER** (`req`=1):
    - Pop with `bus_last` → RELEASE.
    - `grant`=0 → set `grant_err` and go to RELEASE.
  - **RELEASE** (`req`=0): stay until `grant`=0 is sampled, then → IDLE.
- **Outputs:**
  - `req` is registered from the next-state value: it is 1 in REQ and XFER.
  - `bus_valid = req && grant && !empty`. It is combinational, so the first beat can go out in the same cycle grant is first seen in REQ. That beat moves the FSM to XFER, or straight to RELEASE if it is a single-beat burst.
  - `bus_data` and `bus_last` show the FIFO head; they are don't-care while `bus_valid`=0.
- **`grant_err`:** sticky until `rst`. Also set if `grant`=1 is seen in IDLE.

## Timing
- **Reset values:**
  - `req`=0, `bus_valid`=0, `grant_err`=0, `in_ready`=0 while `rst` is high.
  - FIFO empty, `bursts`=0, state IDLE.
  - `in_ready` becomes 1 in the first cycle after `rst` falls.
- **Reset mid-burst:** the FIFO is discarded and `req` drops at the next edge. The arbiter releases `grant` one cycle later; `bus_valid` stays 0 throughout because it is gated by `req`.
- **Latency, push of last beat at edge E0:**
  - `bursts` nonzero in cycle E0..E1.
  - `req`=1 from E1.
  - Arbiter `grant` earliest from E2.
  - First `bus_valid` in cycle E2..E3.
- **Release, last beat accepted at edge En:**
  - `req`=0 from En.
  - `grant` falls at En+1.
  - IDLE from En+2 at earliest.
  - Next `req` from En+3 at earliest.
  - No beat is driven while `grant` is still high in RELEASE.
- **Back-to-back bursts:** the FIFO keeps accepting during XFER and RELEASE. The next burst restarts through IDLE; it is never merged into the current grant.
- **Throughput:** 1 beat per cycle while granted with `bus_ready`=1.

## Structure
- Package `arb_pkg`: `arb_req_state_e` enum {IDLE, REQ, XFER, RELEASE}. The arbiter test env shares it.
- Sub-module `sync_fifo #(W, DEPTH)`:
  - Registered read/write pointers with a wrap bit.
  - Exposes `full`, `empty`, and `count`.
  - Synchronous active-high reset.
  - Data storage not reset.
- `arb_requester` adds the `bursts` counter, the FSM, and output gating.

## Test plan
- **Reset:** hold `rst` 3 cycles with `in_valid`=1 → `in_ready`=0, `req`=0, `bus_valid`=0; FIFO is empty afterward.
- **Single burst:** push 3 beats (0xA0, 0xA1, 0xA2+last); arbiter model grants 1 cycle after `req`; `bus_ready`=1.
  - `req` rises 1 cycle after the last push.
  - Beats appear on 3 consecutive cycles with `bus_last` on 0xA2.
  - `req`=0 the following cycle.
- **Backpressure:** same burst with `bus_ready` toggling 1,0,1,0,1 → data order preserved; each beat held stable while not accepted.
- **Oversize burst:** `DEPTH`=8, 12-beat burst with producer stalled after 8 beats.
  - `req` asserts on full and 8 beats transfer.
  - `bus_valid`=0 until the producer resumes; the remaining 4 beats complete in the same grant.
- **Back-to-back with release:** two 1-beat bursts pushed together.
  - Second `req` no earlier than 3 cycles after the first beat is accepted.
  - No beat sent while `req`=0.
- **Error and reset mid-burst:**
  - Drop `grant` during XFER → `grant_err`=1 and sticky, FSM in RELEASE.
  - Then assert `rst` mid-burst → `req`=0 next cycle and `grant_err` clears.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter requester and its test environment.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } arb_req_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; storage is not reset.
module sync_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_en_i,
  input  logic [W-1:0]              wr_data_i,
  input  logic                      rd_en_i,
  output logic [W-1:0]              rd_data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wr_ok, rd_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  // A write at full is only safe when the head slot is freed in the same cycle.
  assign wr_ok    = wr_en_i && (!full_o || rd_en_i);
  assign rd_ok    = rd_en_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + PW'(wr_ok);
  assign rd_ptr_d = rd_ptr_q + PW'(rd_ok);

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/arb_requester.sv
// Requester-side arbiter agent: buffers producer bursts, requests the shared
// bus once a burst (or a full FIFO) is ready, and streams beats while granted.
module arb_requester
  import arb_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_last_i,
  output logic          req_o,
  input  logic          grant_i,
  output logic          bus_valid_o,
  input  logic          bus_ready_i,
  output logic [DW-1:0] bus_data_o,
  output logic          bus_last_o,
  output logic          grant_err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  arb_req_state_e state_q, state_d;
  logic           req_q, req_d;
  logic           err_q, err_d;
  logic [CW-1:0]  bursts_q, bursts_d;

  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [DW:0]    fifo_head;
  logic           push, pop, pop_last, start;

  sync_fifo #(
    .W     (DW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (push),
    .wr_data_i ({in_last_i, in_data_i}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign in_ready_o  = !fifo_full && !rst_i;
  assign bus_valid_o = req_q && grant_i && !fifo_empty;
  assign bus_data_o  = fifo_head[DW-1:0];
  assign bus_last_o  = fifo_head[DW];
  assign req_o       = req_q;
  assign grant_err_o = err_q;

  assign push     = in_valid_i && in_ready_o;
  assign pop      = bus_valid_o && bus_ready_i;
  assign pop_last = pop && bus_last_o;
  // A full FIFO without a last beat still starts, so oversize bursts drain.
  assign start    = (bursts_q != '0) || (fifo_count == CW'(DEPTH));

  always_comb begin
    bursts_d = bursts_q;
    case ({push && in_last_i, pop_last})
      2'b10:   bursts_d = bursts_q + CW'(1);
      2'b01:   bursts_d = bursts_q - CW'(1);
      default: bursts_d = bursts_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant_i) err_d = 1'b1;
        if (start) state_d = REQ;
      end
      REQ: begin
        if (grant_i) state_d = pop_last ? RELEASE : XFER;
      end
      XFER: begin
        if (pop_last) begin
          state_d = RELEASE;
        end else if (!grant_i) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!grant_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_d = (state_d == REQ) || (state_d == XFER);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      bursts_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      err_q    <= err_d;
      bursts_q <= bursts_d;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// Scoreboard bench for arb_requester with a one-cycle registered arbiter model.
module tb_arb_requester;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          req;
  logic          grant = 1'b0;
  logic          bus_valid;
  logic          bus_ready = 1'b1;
  logic [DW-1:0] bus_data;
  logic          bus_last;
  logic          grant_err;

  logic          drop_grant = 1'b0;
  int            rdy_mode = 0;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_mis = 0;

  logic [DW:0]   exp_q[$];
  int            acc_q[$];
  int            rise_q[$];
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_beat = '0;
  logic          req_prev = 1'b0;

  arb_requester #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .req_o       (req),
    .grant_i     (grant),
    .bus_valid_o (bus_valid),
    .bus_ready_i (bus_ready),
    .bus_data_o  (bus_data),
    .bus_last_o  (bus_last),
    .grant_err_o (grant_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Arbiter model: grant follows req one cycle later unless forced low.
  always @(posedge clk) grant <= req && !drop_grant;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus_ready = 1'b1;
      1:       bus_ready = ~bus_ready;
      default: bus_ready = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      req_prev   = 1'b0;
    end else begin
      if (req && !req_prev) rise_q.push_back(cyc);
      req_prev = req;
      if (prev_stall && grant) begin
        check("hold_valid", 64'(bus_valid), 64'(1));
        check("hold_beat", 64'({bus_last, bus_data}), 64'(prev_beat));
      end
      if (bus_valid) begin
        check("valid_needs_req", 64'(req), 64'(1));
        if (bus_ready) begin
          acc_q.push_back(cyc);
          check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0)
            check("beat", 64'({bus_last, bus_data}), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = bus_valid && !bus_ready;
      prev_beat  = {bus_last, bus_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic l);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'(1));
    else exp_q.push_back({l, d});
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_burst(input logic [DW-1:0] base, input int n, input bit last_on_end);
    for (int i = 0; i < n; i++)
      push_beat(base + DW'(i), last_on_end && (i == n - 1));
  endtask

  task automatic wait_acc(input int n, input string tag);
    int w = 0;
    while (acc_q.size() < n && w < 200) begin
      tick();
      w++;
    end
    check(tag, 64'(acc_q.size()), 64'(n));
  endtask

  task automatic wait_grant(input logic val, input string tag);
    int w = 0;
    while (grant !== val && w < 50) begin
      tick();
      w++;
    end
    check(tag, 64'(grant), 64'(val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int w;

    // Reset held with the producer pushing.
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
    repeat (3) begin
      tick();
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_req", 64'(req), 64'(0));
      check("rst_bus_valid", 64'(bus_valid), 64'(0));
      check("rst_grant_err", 64'(grant_err), 64'(0));
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    repeat (3) tick();
    check("post_rst_fifo_empty_req", 64'(req), 64'(0));
    check("post_rst_bus_valid", 64'(bus_valid), 64'(0));

    // Single burst.
    acc_q.delete();
    push_burst(32'hA0, 3, 1'b1);
    t0 = cyc;
    check("sb_req_before", 64'(req), 64'(0));
    tick();
    check("sb_req_rise", 64'(req), 64'(1));
    wait_acc(3, "sb_beats");
    check("sb_req_drop", 64'(req), 64'(0));
    if (acc_q.size() == 3) begin
      check("sb_first_beat_cyc", 64'(acc_q[0]), 64'(t0 + 2));
      check("sb_consecutive", 64'(acc_q[2] - acc_q[0]), 64'(2));
    end
    check("sb_sb_empty", 64'(exp_q.size()), 64'(0));
    repeat (4) tick();

    // Backpressure: bus_ready toggles every cycle.
    rdy_mode = 1;
    acc_q.delete();
    push_burst(32'hA0, 3, 1'b1);
    wait_acc(3, "bp_beats");
    check("bp_sb_empty", 64'(exp_q.size()), 64'(0));
    rdy_mode = 0;
    repeat (5) tick();

    // Oversize burst: 8 beats fill the FIFO, producer stalls, 4 more follow.
    acc_q.delete();
    push_burst(32'hB0, 7, 1'b0);
    check("os_no_req_partial", 64'(req), 64'(0));
    push_beat(32'hB7, 1'b0);
    check("os_req_before_full", 64'(req), 64'(0));
    tick();
    check("os_req_on_full", 64'(req), 64'(1));
    wait_acc(8, "os_first8");
    repeat (3) begin
      tick();
      check("os_idle_gap_valid", 64'(bus_valid), 64'(0));
      check("os_gap_req_held", 64'(req), 64'(1));
    end
    for (int i = 8; i < 12; i++) push_beat(32'hB0 + DW'(i), i == 11);
    wait_acc(12, "os_all12");
    check("os_req_drop", 64'(req), 64'(0));
    check("os_sb_empty", 64'(exp_q.size()), 64'(0));
    repeat (5) tick();

    // Back-to-back single-beat bursts must go through RELEASE and IDLE.
    acc_q.delete();
    rise_q.delete();
    push_beat(32'hC0, 1'b1);
    push_beat(32'hC1, 1'b1);
    wait_acc(2, "b2b_beats");
    check("b2b_rises", 64'(rise_q.size()), 64'(2));
    if (rise_q.size() == 2 && acc_q.size() == 2) begin
      check("b2b_gap_ok", 64'((rise_q[1] - acc_q[0] >= 4) && (rise_q[1] - acc_q[0] <= 8)), 64'(1));
      check("b2b_second_beat", 64'(acc_q[1]), 64'(rise_q[1] + 1));
    end
    repeat (5) tick();

    // Grant lost mid-burst, then reset mid-burst.
    rdy_mode = 2;
    repeat (2) tick();
    push_burst(32'hD0, 4, 1'b1);
    wait_grant(1'b1, "err_grant_up");
    tick();
    drop_grant = 1'b1;
    w = 0;
    while (!grant_err && w < 20) begin
      tick();
      w++;
    end
    check("err_set", 64'(grant_err), 64'(1));
    check("err_release_req", 64'(req), 64'(0));
    check("err_no_valid", 64'(bus_valid), 64'(0));
    repeat (3) tick();
    check("err_sticky", 64'(grant_err), 64'(1));
    drop_grant = 1'b0;
    wait_grant(1'b1, "err_regrant");
    tick();
    check("err_sticky_regrant", 64'(grant_err), 64'(1));
    check("err_regrant_req", 64'(req), 64'(1));
    rst = 1'b1;
    tick();
    check("mid_rst_req", 64'(req), 64'(0));
    check("mid_rst_err_clr", 64'(grant_err), 64'(0));
    check("mid_rst_valid", 64'(bus_valid), 64'(0));
    repeat (2) tick();
    exp_q.delete();
    rst      = 1'b0;
    rdy_mode = 0;
    repeat (4) tick();
    check("post_mid_rst_req", 64'(req), 64'(0));
    check("post_mid_rst_err", 64'(grant_err), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
